piso_serializer: RTL

//  Parallel-in/serial-out stage that feeds the 11011 Mealy sequence detector.

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer.sv | 73 +++++++
 2 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial-chain blocks: state encoding and default word width.
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int unsigned SER_DEFAULT_WIDTH = 8;

   // Bit-counter width; never narrower than one bit.
   function automatic int unsigned ser_cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words over valid/ready and
// streams them one bit per clock on sout, back-to-back words without a gap.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = SER_DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy
);

   localparam int unsigned     CNT_W = ser_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   ser_state_t       state;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic             last_bit;
   logic             load;

   function automatic logic head(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-1] : word[0];
   endfunction

   function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? (word << 1) : (word >> 1);
   endfunction

   // Ready depends only on state/bit_cnt, never on din_valid.
   always_comb begin
      last_bit  = (state == SHIFT) && (bit_cnt == LAST);
      din_ready = (state == IDLE) || last_bit;
      load      = din_valid && din_ready;
      busy      = (state == SHIFT);
   end

   // sout is registered, so the first bit is driven straight from din on the
   // accepting edge and shift_reg keeps only the bits still to be sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
      end else if (load) begin
         state      <= SHIFT;
         shift_reg  <= tail(din);
         bit_cnt    <= '0;
         sout       <= head(din);
         sout_valid <= 1'b1;
      end else if ((state == SHIFT) && !last_bit) begin
         shift_reg  <= tail(shift_reg);
         bit_cnt    <= bit_cnt + 1'b1;
         sout       <= head(shift_reg);
         sout_valid <= 1'b1;
      end else begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
      end
   end

endmodule
